mult_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the register file read ports. operandA is driven by sourceReg (rs) and operandB by secondaryReg (rt).
- Executes MULT/MULTU/DIV/DIVU over 32 cycles and holds the results in HI/LO for MFHI/MFLO.
- Also services MTHI/MTLO writes.

---
 rtl/mult_div_unit.sv | 190 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS datapath: shift-add MULT, restoring DIV.
// Define MDU_SIGNED_EN to add signed MULT/DIV (op[1]); otherwise op[1] is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiWrite,
  input  logic             loWrite,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } stateT;

  stateT             state;
  logic [CW-1:0]     counter;
  logic [2*WIDTH-1:0] prodAcc;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  remAcc;
  logic [WIDTH-1:0]  quotAcc;
  logic [WIDTH-1:0]  divisor;
  logic [WIDTH-1:0]  dividendLatched;

  logic [WIDTH-1:0]   startA;
  logic [WIDTH-1:0]   startB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] prodNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divTrial;
  logic               quotBit;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quotNext;
  logic [2*WIDTH-1:0] finalProd;
  logic [WIDTH-1:0]   finalQuot;
  logic [WIDTH-1:0]   finalRem;

`ifdef MDU_SIGNED_EN
  logic signA;
  logic signB;
  logic negProd;
  logic negQuot;
  logic negRem;

  // Signed operations run on magnitudes; the most negative value is its own unsigned magnitude.
  always_comb begin
    signA  = op[1] & operandA[WIDTH-1];
    signB  = op[1] & operandB[WIDTH-1];
    startA = signA ? -operandA : operandA;
    startB = signB ? -operandB : operandB;
  end
`else
  logic unusedOpSign;
  assign unusedOpSign = op[1];

  always_comb begin
    startA = operandA;
    startB = operandB;
  end
`endif

  // One shift-add step: the low half of the accumulator holds the remaining multiplier bits.
  always_comb begin
    mulSum   = {1'b0, prodAcc[2*WIDTH-1:WIDTH]} + {1'b0, (prodAcc[0] ? mcand : {WIDTH{1'b0}})};
    prodNext = {mulSum, prodAcc[WIDTH-1:1]};
  end

  // One restoring step: a borrow out of the trial subtract means the quotient bit is zero.
  always_comb begin
    divShift = {remAcc, quotAcc[WIDTH-1]};
    divTrial = divShift - {1'b0, divisor};
    quotBit  = ~divTrial[WIDTH];
    remNext  = quotBit ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
    quotNext = {quotAcc[WIDTH-2:0], quotBit};
  end

  always_comb begin
    finalProd = prodNext;
    finalQuot = quotNext;
    finalRem  = remNext;
`ifdef MDU_SIGNED_EN
    if (negProd) finalProd = -prodNext;
    if (negQuot) finalQuot = -quotNext;
    if (negRem)  finalRem  = -remNext;
`endif
  end

  // Control, iteration and HI/LO update; HI/LO only change at completion or via MTHI/MTLO.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state           <= IDLE;
      counter         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      divByZero       <= 1'b0;
      hi              <= '0;
      lo              <= '0;
      prodAcc         <= '0;
      mcand           <= '0;
      remAcc          <= '0;
      quotAcc         <= '0;
      divisor         <= '0;
      dividendLatched <= '0;
`ifdef MDU_SIGNED_EN
      negProd         <= 1'b0;
      negQuot         <= 1'b0;
      negRem          <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= op[0] ? DIV : MUL;
            busy            <= 1'b1;
            divByZero       <= 1'b0;
            counter         <= '0;
            prodAcc         <= {{WIDTH{1'b0}}, startB};
            mcand           <= startA;
            remAcc          <= '0;
            quotAcc         <= startA;
            divisor         <= startB;
            dividendLatched <= operandA;
`ifdef MDU_SIGNED_EN
            negProd         <= signA ^ signB;
            negQuot         <= signA ^ signB;
            negRem          <= signA;
`endif
          end else begin
            if (hiWrite) hi <= operandA;
            if (loWrite) lo <= operandA;
          end
        end

        MUL: begin
          prodAcc <= prodNext;
          counter <= counter + 1'b1;
          if (counter == LAST_COUNT) begin
            hi      <= finalProd[2*WIDTH-1:WIDTH];
            lo      <= finalProd[WIDTH-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end
        end

        DIV: begin
          remAcc  <= remNext;
          quotAcc <= quotNext;
          counter <= counter + 1'b1;
          if (counter == LAST_COUNT) begin
            if (divisor == '0) begin
              lo        <= '1;
              hi        <= dividendLatched;
              divByZero <= 1'b1;
            end else begin
              lo <= finalQuot;
              hi <= finalRem;
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/divByZero queued at launch, checked on done.
// Expectations for MULT/DIV follow MDU_SIGNED_EN when it is defined for the build.
module tb_mult_div_unit;

  logic        Clk;
  logic        Rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        hiWrite;
  logic        loWrite;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } resultT;

  resultT expQ[$];
  int compareCount  = 0;
  int mismatchCount = 0;
  int doneCount     = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .start(start),
    .op(op),
    .operandA(operandA),
    .operandB(operandB),
    .hiWrite(hiWrite),
    .loWrite(loWrite),
    .busy(busy),
    .done(done),
    .divByZero(divByZero),
    .hi(hi),
    .lo(lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pushes the expected result and holds start for one edge.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo, input logic expDbz);
    resultT r;
    r.hi  = expHi;
    r.lo  = expLo;
    r.dbz = expDbz;
    expQ.push_back(r);
    op       = opIn;
    operandA = a;
    operandB = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitDone(output int busyCycles);
    busyCycles = 0;
    while (!done && busyCycles < 200) begin
      if (busy) busyCycles++;
      tick();
    end
    checkOutput("doneSeen", {63'd0, done}, 64'd1);
    checkOutput("busyAtDone", {63'd0, busy}, 64'd0);
  endtask

  function automatic resultT modelU(input logic isDiv, input logic [31:0] a, input logic [31:0] b);
    resultT r;
    logic [63:0] p;
    r.dbz = 1'b0;
    if (!isDiv) begin
      p    = {32'd0, a} * {32'd0, b};
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 32'd0) begin
      r.hi  = a;
      r.lo  = 32'hFFFF_FFFF;
      r.dbz = 1'b1;
    end else begin
      r.hi = a % b;
      r.lo = a / b;
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Rst_n && done) begin
      resultT r;
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("spuriousDone", 64'd1, 64'd0);
      end else begin
        r = expQ.pop_front();
        checkOutput("hi", {32'd0, hi}, {32'd0, r.hi});
        checkOutput("lo", {32'd0, lo}, {32'd0, r.lo});
        checkOutput("divByZero", {63'd0, divByZero}, {63'd0, r.dbz});
      end
    end
  end

  initial begin
    int cycles;
    int doneBefore;
    resultT r;
    logic [31:0] a;
    logic [31:0] b;

    Rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    operandA = '0;
    operandB = '0;
    hiWrite  = 1'b0;
    loWrite  = 1'b0;
    #23;
    checkOutput("resetBusy", {63'd0, busy}, 64'd0);
    checkOutput("resetDone", {63'd0, done}, 64'd0);
    checkOutput("resetDbz", {63'd0, divByZero}, 64'd0);
    checkOutput("resetHi", {32'd0, hi}, 64'd0);
    checkOutput("resetLo", {32'd0, lo}, 64'd0);
    Rst_n = 1'b1;
    tick();

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    waitDone(cycles);
    checkOutput("multuLatency", 64'(cycles), 64'd32);

    applyStimulus(2'b01, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
    repeat (4) tick();
    op       = 2'b00;
    operandA = 32'd9;
    operandB = 32'd9;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    waitDone(cycles);
    checkOutput("divuLatencyIgnoredStart", 64'(cycles), 64'd27);

    applyStimulus(2'b01, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    waitDone(cycles);
    repeat (3) tick();
    checkOutput("dbzHeld", {63'd0, divByZero}, 64'd1);
    applyStimulus(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    checkOutput("dbzClearedAtStart", {63'd0, divByZero}, 64'd0);
    waitDone(cycles);

`ifdef MDU_SIGNED_EN
    applyStimulus(2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    waitDone(cycles);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    waitDone(cycles);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    waitDone(cycles);
`else
    applyStimulus(2'b10, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
    waitDone(cycles);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    waitDone(cycles);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
    waitDone(cycles);
`endif
    applyStimulus(2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    waitDone(cycles);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? $urandom : $urandom_range(1, 1000);
      r = modelU(i[0], a, b);
      applyStimulus({1'b0, i[0]}, a, b, r.hi, r.lo, r.dbz);
      waitDone(cycles);
    end

    loWrite  = 1'b1;
    operandA = 32'hCAFE_F00D;
    tick();
    loWrite  = 1'b0;
    checkOutput("mtlo", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});
    hiWrite  = 1'b1;
    loWrite  = 1'b1;
    operandA = 32'h1234_5678;
    tick();
    hiWrite  = 1'b0;
    loWrite  = 1'b0;
    checkOutput("mthiBothHi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    checkOutput("mthiBothLo", {32'd0, lo}, {32'd0, 32'h1234_5678});

    hiWrite = 1'b1;
    applyStimulus(2'b00, 32'h0000_AAAA, 32'd2, 32'd0, 32'h0001_5554, 1'b0);
    hiWrite = 1'b0;
    checkOutput("startBeatsWrite", {32'd0, hi}, {32'd0, 32'h1234_5678});
    repeat (3) tick();
    hiWrite  = 1'b1;
    operandA = 32'h0000_DEAD;
    tick();
    hiWrite  = 1'b0;
    checkOutput("writeIgnoredBusy", {32'd0, hi}, {32'd0, 32'h1234_5678});
    checkOutput("loHeldBusy", {32'd0, lo}, {32'd0, 32'h1234_5678});
    waitDone(cycles);

    loWrite  = 1'b1;
    operandA = 32'hCAFE_F00D;
    tick();
    loWrite  = 1'b0;
    checkOutput("mtloAgain", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});
    applyStimulus(2'b00, 32'd12345, 32'd678, 32'd0, 32'd0, 1'b0);
    repeat (9) tick();
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", {63'd0, busy}, 64'd0);
    checkOutput("midResetHi", {32'd0, hi}, 64'd0);
    checkOutput("midResetLo", {32'd0, lo}, 64'd0);
    expQ.delete();
    doneBefore = doneCount;
    tick();
    Rst_n = 1'b1;
    repeat (40) tick();
    checkOutput("noDoneAfterReset", 64'(doneCount - doneBefore), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
